store_monitor: RTL and testbench
================================

# store_monitor

Synthesizable store-side monitor that sits directly downstream of the multicycle `cpu` core's data-memory write port (`memwrite`, `dataaddr`, `writedata`, `pc`). It logs every store into a small first-word-fall-through FIFO and counts cycles and stores. It also issues a sticky pass/fail/timeout verdict against one programmed expected (address, data) pair. This replaces per-program ad-hoc timing checks in benches, and the same verdict can be exported to an FPGA LED or UART.

## Interface
- `LOG_DEPTH`, 8: store-log FIFO entries; power of two, at least 2.
- `CYC_W`, 16: width of cycle counter and `max_cycles`.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising `clk`.
- `memwrite` in 1: CPU store strobe; one store per high cycle.
- `dataaddr` in 32: CPU store address.
- `writedata` in 32: CPU store data.
- `pc` in 32: CPU program counter, logged alongside each store.
- `start` in 1: one-cycle pulse; arms or re-arms a run.
- `exp_addr` in 32: target store address; sampled at `start`.
- `exp_data` in 32: expected data at target; sampled at `start`.
- `max_cycles` in `CYC_W`: timeout budget in cycles; sampled at `start`; 0 means no timeout.
- `done` out 1: verdict reached (PASS or FAIL state).
- `pass` out 1: target store matched.
- `fail` out 1: target mismatch or timeout.
- `timeout` out 1: fail caused by budget expiry.
- `cycle_count` out `CYC_W`: cycles spent in RUN; saturates at all-ones.
- `store_count` out 16: stores seen in RUN; saturates.
- `log_valid` out 1: FIFO non-empty.
- `log_addr`, `log_data`, `log_pc` out 32 each: FIFO head entry.
- `log_rd_en` in 1: pop head; ignored when `!log_valid`.
- `log_overflow` out 1: sticky; at least one store dropped because FIFO full.

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset (`reset`=0) gives IDLE. All counters and flags are 0, the FIFO is empty, and the sampled expectations are 0.
- IDLE: `memwrite` ignored; `start` goes to RUN.
- `start` in any state: go to RUN. Clear `cycle_count`, `store_count`, `timeout`, `log_overflow`, and the FIFO. Latch `exp_addr`, `exp_data`, `max_cycles`. A store coinciding with `start` is ignored.
- RUN, each cycle (not the `start` cycle): `cycle_count` increments.
- RUN with `memwrite`=1:
  - Push {dataaddr, writedata, pc} unless the FIFO is full; if full, drop the store and set `log_overflow`.
  - Increment `store_count`.
  - If `dataaddr`==latched `exp_addr`: go to PASS if `writedata`==`exp_data`, else FAIL.
- RUN timeout: if `max_cycles`≠0 and `cycle_count`==`max_cycles`-1 at the edge, go to FAIL with `timeout`=1.
- A target store on the timeout cycle takes priority and gives PASS or FAIL, with `timeout`=0.
- PASS and FAIL are sticky until `start` or reset. Counters freeze, `memwrite` is ignored, and the FIFO can still be popped.
- FIFO: a push and a pop in the same cycle are both honoured, including when full, so no overflow occurs in that case. Pointers wrap modulo `LOG_DEPTH`. A pop when empty is a no-op.
- Non-target stores never affect the verdict.

## Timing
- Outputs `done`, `pass`, `fail`, `timeout`, and the counters are registered.
- Verdict latency: asserted on the edge ending the qualifying `memwrite` cycle, so it is visible 1 cycle later.
- Log entry latency: `log_valid` and head fields are visible the cycle after the push edge.
- Pop latency: after a pop edge, the next entry (or `log_valid`=0) is visible.
- `log_*` are driven from FIFO storage and are valid whenever `log_valid`=1.
- Reset is synchronous. Reset asserted mid-RUN takes effect at that edge, overriding `start` and `memwrite`.
- `done` = `pass` | `fail`. `pass` and `fail` are never both 1.

## Test plan
- Jump program:
  - Stimulus: `start` with exp_addr=6, exp_data=6, max_cycles=19. The CPU executes the jump test, storing 6 to address 6 at cycle 18.
  - Response: `pass`=1, `done`=1, `cycle_count`=18, `store_count`=1, and the log head shows addr 6, data 6.
- Mismatch:
  - Stimulus: same setup, but the driven store is data 7 to address 6.
  - Response: `fail`=1, `timeout`=0.
  - Then a later store of 6 to address 6 → the verdict is unchanged.
- Timeout:
  - Stimulus: max_cycles=5 with no stores.
  - Response: `fail`=1 and `timeout`=1 one cycle after the 5th RUN cycle; `cycle_count`=5.
  - Variant: a target-match store exactly on that cycle → `pass`=1 and `timeout`=0.
- Overflow:
  - Stimulus: LOG_DEPTH=8; 10 consecutive non-target stores to addresses 0x10..0x19, with no pops.
  - Response: `store_count`=10, `log_overflow`=1, and popping yields exactly 0x10..0x17, then `log_valid`=0.
  - Variant: the full FIFO is pushed and popped in the same cycle → no overflow.
- Reset and restart:
  - Stimulus: reset asserted low mid-RUN.
  - Response: all outputs are 0 on the next cycle and the state is IDLE.
  - Stimulus: `start` pulsed while in PASS.
  - Response: counters clear, the FIFO empties, and `done`=0.

Source files
------------

// File: rtl/store_monitor.sv
// Store-side monitor for the multicycle CPU data-memory write port: logs stores
// into a first-word-fall-through FIFO, counts RUN cycles/stores, and gives a sticky verdict.
module store_monitor #(
  parameter int LOG_DEPTH = 8,
  parameter int CYC_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataaddr,
  input  logic [31:0]      writedata,
  input  logic [31:0]      pc,
  input  logic             start,
  input  logic [31:0]      exp_addr,
  input  logic [31:0]      exp_data,
  input  logic [CYC_W-1:0] max_cycles,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count,
  output logic [15:0]      store_count,
  output logic             log_valid,
  output logic [31:0]      log_addr,
  output logic [31:0]      log_data,
  output logic [31:0]      log_pc,
  input  logic             log_rd_en,
  output logic             log_overflow
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   FILL_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FILL_MAX = (PTR_W + 1)'(LOG_DEPTH);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]      exp_addr_reg, exp_addr_next;
  logic [31:0]      exp_data_reg, exp_data_next;
  logic [CYC_W-1:0] max_cycles_reg, max_cycles_next;
  logic [CYC_W-1:0] cycle_count_reg, cycle_count_next;
  logic [15:0]      store_count_reg, store_count_next;
  logic             timeout_reg, timeout_next;
  logic             overflow_reg, overflow_next;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   fill_reg, fill_next;

  logic [31:0] addr_mem [LOG_DEPTH];
  logic [31:0] data_mem [LOG_DEPTH];
  logic [31:0] pc_mem   [LOG_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic run_store;
  logic push;
  logic pop;
  logic target_hit;
  logic budget_hit;

  // A start pulse wins over everything else in its cycle, including stores and pops.
  always_comb begin
    fifo_empty = (fill_reg == '0);
    fifo_full  = (fill_reg == FILL_MAX);
    run_store  = (state_reg == S_RUN) && memwrite && !start;
    pop        = log_rd_en && !fifo_empty && !start;
    push       = run_store && (!fifo_full || pop);
    target_hit = run_store && (dataaddr == exp_addr_reg);
    budget_hit = (state_reg == S_RUN) && !start && (max_cycles_reg != '0) &&
                 (cycle_count_reg == (max_cycles_reg - CYC_ONE));
  end

  always_comb begin
    state_next       = state_reg;
    exp_addr_next    = exp_addr_reg;
    exp_data_next    = exp_data_reg;
    max_cycles_next  = max_cycles_reg;
    cycle_count_next = cycle_count_reg;
    store_count_next = store_count_reg;
    timeout_next     = timeout_reg;
    overflow_next    = overflow_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    fill_next        = fill_reg;

    if (start) begin
      state_next       = S_RUN;
      exp_addr_next    = exp_addr;
      exp_data_next    = exp_data;
      max_cycles_next  = max_cycles;
      cycle_count_next = '0;
      store_count_next = '0;
      timeout_next     = 1'b0;
      overflow_next    = 1'b0;
      wr_ptr_next      = '0;
      rd_ptr_next      = '0;
      fill_next        = '0;
    end else begin
      if (state_reg == S_RUN) begin
        if (cycle_count_reg != '1) begin
          cycle_count_next = cycle_count_reg + CYC_ONE;
        end
        if (memwrite && (store_count_reg != 16'hFFFF)) begin
          store_count_next = store_count_reg + 16'd1;
        end
        if (run_store && !push) begin
          overflow_next = 1'b1;
        end
        // A target store on the budget's last cycle decides the verdict on its own.
        if (target_hit) begin
          state_next = (writedata == exp_data_reg) ? S_PASS : S_FAIL;
        end else if (budget_hit) begin
          state_next   = S_FAIL;
          timeout_next = 1'b1;
        end
      end

      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fill_next = fill_reg + FILL_ONE;
        2'b01:   fill_next = fill_reg - FILL_ONE;
        default: fill_next = fill_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      exp_addr_reg    <= '0;
      exp_data_reg    <= '0;
      max_cycles_reg  <= '0;
      cycle_count_reg <= '0;
      store_count_reg <= '0;
      timeout_reg     <= 1'b0;
      overflow_reg    <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fill_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      exp_addr_reg    <= exp_addr_next;
      exp_data_reg    <= exp_data_next;
      max_cycles_reg  <= max_cycles_next;
      cycle_count_reg <= cycle_count_next;
      store_count_reg <= store_count_next;
      timeout_reg     <= timeout_next;
      overflow_reg    <= overflow_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      fill_reg        <= fill_next;
    end
  end

  // Log storage carries no reset; the fill count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      addr_mem[wr_ptr_reg] <= dataaddr;
      data_mem[wr_ptr_reg] <= writedata;
      pc_mem[wr_ptr_reg]   <= pc;
    end
  end

  assign pass         = (state_reg == S_PASS);
  assign fail         = (state_reg == S_FAIL);
  assign done         = pass | fail;
  assign timeout      = timeout_reg;
  assign cycle_count  = cycle_count_reg;
  assign store_count  = store_count_reg;
  assign log_overflow = overflow_reg;
  assign log_valid    = !fifo_empty;
  assign log_addr     = log_valid ? addr_mem[rd_ptr_reg] : '0;
  assign log_data     = log_valid ? data_mem[rd_ptr_reg] : '0;
  assign log_pc       = log_valid ? pc_mem[rd_ptr_reg]   : '0;

endmodule

// File: tb/tb_store_monitor.sv
// Randomized and directed bench for store_monitor, compared every cycle
// against a queue-based reference model of the monitor's rules.
module tb_store_monitor;

  localparam int LOG_DEPTH = 8;
  localparam int CYC_W     = 16;
  localparam int CYC_MAX   = (1 << CYC_W) - 1;

  logic             clk;
  logic             reset;
  logic             memwrite;
  logic [31:0]      dataaddr;
  logic [31:0]      writedata;
  logic [31:0]      pc;
  logic             start;
  logic [31:0]      exp_addr;
  logic [31:0]      exp_data;
  logic [CYC_W-1:0] max_cycles;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [CYC_W-1:0] cycle_count;
  logic [15:0]      store_count;
  logic             log_valid;
  logic [31:0]      log_addr;
  logic [31:0]      log_data;
  logic [31:0]      log_pc;
  logic             log_rd_en;
  logic             log_overflow;

  store_monitor #(.LOG_DEPTH(LOG_DEPTH), .CYC_W(CYC_W)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
    .writedata(writedata), .pc(pc), .start(start), .exp_addr(exp_addr),
    .exp_data(exp_data), .max_cycles(max_cycles), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .cycle_count(cycle_count),
    .store_count(store_count), .log_valid(log_valid), .log_addr(log_addr),
    .log_data(log_data), .log_pc(log_pc), .log_rd_en(log_rd_en),
    .log_overflow(log_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: a log queue plus verdict flags and plain integer counters.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t        m_log[$];
  bit          m_running, m_pass, m_fail, m_timeout, m_ovf;
  int          m_cyc, m_st;
  logic [31:0] m_exp_a, m_exp_d;
  int          m_max;

  task automatic model_edge();
    bit   pop_ok, push_ok, hit;
    ent_t e;
    int   old_cyc;
    if (!reset) begin
      m_running = 0; m_pass = 0; m_fail = 0; m_timeout = 0; m_ovf = 0;
      m_cyc = 0; m_st = 0; m_exp_a = 0; m_exp_d = 0; m_max = 0;
      m_log.delete();
    end else if (start) begin
      m_running = 1; m_pass = 0; m_fail = 0; m_timeout = 0; m_ovf = 0;
      m_cyc = 0; m_st = 0;
      m_exp_a = exp_addr; m_exp_d = exp_data; m_max = int'(max_cycles);
      m_log.delete();
    end else begin
      pop_ok  = log_rd_en && (m_log.size() > 0);
      push_ok = 0;
      if (m_running) begin
        old_cyc = m_cyc;
        if (m_cyc < CYC_MAX) m_cyc++;
        hit = 0;
        if (memwrite) begin
          if (m_log.size() < LOG_DEPTH || pop_ok) push_ok = 1;
          else m_ovf = 1;
          if (m_st < 65535) m_st++;
          if (dataaddr == m_exp_a) begin
            hit = 1;
            m_running = 0;
            if (writedata == m_exp_d) m_pass = 1;
            else m_fail = 1;
          end
        end
        if (!hit && m_max != 0 && old_cyc == m_max - 1) begin
          m_running = 0; m_fail = 1; m_timeout = 1;
        end
      end
      if (pop_ok) void'(m_log.pop_front());
      if (push_ok) begin
        e.a = dataaddr; e.d = writedata; e.p = pc;
        m_log.push_back(e);
      end
    end
  endtask

  task automatic compare_all();
    check("done", done, m_pass | m_fail);
    check("pass", pass, m_pass);
    check("fail", fail, m_fail);
    check("timeout", timeout, m_timeout);
    check("exclusive", pass & fail, 0);
    check("cycle_count", cycle_count, m_cyc);
    check("store_count", store_count, m_st);
    check("log_valid", log_valid, m_log.size() != 0);
    check("log_overflow", log_overflow, m_ovf);
    if (m_log.size() != 0) begin
      check("log_addr", log_addr, m_log[0].a);
      check("log_data", log_data, m_log[0].d);
      check("log_pc", log_pc, m_log[0].p);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] d, input int m);
    start = 1; exp_addr = a; exp_data = d; max_cycles = CYC_W'(m);
    step();
    start = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataaddr = a; writedata = d; pc = $urandom;
    step();
    memwrite = 0;
  endtask

  task automatic pop_one();
    log_rd_en = 1;
    step();
    log_rd_en = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 0; memwrite = 0; dataaddr = 0; writedata = 0; pc = 0;
    start = 0; exp_addr = 0; exp_data = 0; max_cycles = 0; log_rd_en = 0;
    idle(2);
    check("rst_done", done, 0);
    check("rst_cycles", cycle_count, 0);
    reset = 1;
    idle(2);
    check("idle_no_count", cycle_count, 0);

    // Jump program: the target store lands in the 18th RUN cycle.
    do_start(32'd6, 32'd6, 19);
    idle(17);
    store(32'd6, 32'd6);
    $display("txn jump: pass=%0d cycles=%0d stores=%0d", pass, cycle_count, store_count);
    check("jump_pass", pass, 1);
    check("jump_done", done, 1);
    check("jump_cycles", cycle_count, 18);
    check("jump_stores", store_count, 1);
    check("jump_log_addr", log_addr, 6);
    check("jump_log_data", log_data, 6);
    idle(3);
    check("jump_sticky", pass, 1);

    // Restart while in PASS.
    do_start(32'd6, 32'd6, 19);
    $display("txn restart: done=%0d cycles=%0d valid=%0d", done, cycle_count, log_valid);
    check("restart_done", done, 0);
    check("restart_cycles", cycle_count, 0);
    check("restart_stores", store_count, 0);
    check("restart_empty", log_valid, 0);

    // Mismatch, then a later matching store must not change the verdict.
    idle(3);
    store(32'd6, 32'd7);
    $display("txn mismatch: fail=%0d timeout=%0d", fail, timeout);
    check("mis_fail", fail, 1);
    check("mis_timeout", timeout, 0);
    store(32'd6, 32'd6);
    check("mis_sticky_fail", fail, 1);
    check("mis_sticky_pass", pass, 0);
    check("mis_frozen_stores", store_count, 1);

    // Timeout after 5 RUN cycles with no stores.
    do_start(32'd100, 32'd1, 5);
    idle(4);
    check("to_not_yet", fail, 0);
    idle(1);
    $display("txn timeout: fail=%0d timeout=%0d cycles=%0d", fail, timeout, cycle_count);
    check("to_fail", fail, 1);
    check("to_flag", timeout, 1);
    check("to_cycles", cycle_count, 5);

    // Target store exactly on the timeout cycle.
    do_start(32'd100, 32'd1, 5);
    idle(4);
    store(32'd100, 32'd1);
    $display("txn timeout_race: pass=%0d timeout=%0d", pass, timeout);
    check("race_pass", pass, 1);
    check("race_timeout", timeout, 0);

    // Overflow: ten stores into an eight-entry log.
    do_start(32'hFFFF_F000, 32'd0, 0);
    for (int i = 0; i < 10; i++) store(32'h10 + i, i);
    $display("txn overflow: stores=%0d overflow=%0d", store_count, log_overflow);
    check("ovf_stores", store_count, 10);
    check("ovf_flag", log_overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_pop_addr", log_addr, 32'h10 + i);
      pop_one();
    end
    check("ovf_drained", log_valid, 0);

    // Full log pushed and popped in the same cycle: no overflow.
    do_start(32'hFFFF_F000, 32'd0, 0);
    for (int i = 0; i < 8; i++) store(32'h20 + i, i);
    log_rd_en = 1;
    store(32'h28, 32'd8);
    log_rd_en = 0;
    $display("txn full_pushpop: overflow=%0d head=0x%0h", log_overflow, log_addr);
    check("pp_no_ovf", log_overflow, 0);
    check("pp_head", log_addr, 32'h21);

    // Reset mid-RUN overrides a coincident start and store.
    do_start(32'd6, 32'd6, 0);
    store(32'd1, 32'd1);
    idle(2);
    reset = 0; start = 1; memwrite = 1; dataaddr = 6; writedata = 6;
    step();
    reset = 1; start = 0; memwrite = 0;
    $display("txn reset: done=%0d cycles=%0d valid=%0d", done, cycle_count, log_valid);
    check("mrst_done", done, 0);
    check("mrst_cycles", cycle_count, 0);
    check("mrst_stores", store_count, 0);
    check("mrst_valid", log_valid, 0);
    check("mrst_addr", log_addr, 0);
    idle(2);
    check("mrst_idle", cycle_count, 0);

    // Randomized runs against the model.
    for (int r = 0; r < 30; r++) begin
      do_start($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 60));
      for (int c = 0; c < 80; c++) begin
        memwrite  = ($urandom_range(0, 99) < 40);
        dataaddr  = $urandom_range(0, 7);
        writedata = $urandom_range(0, 3);
        pc        = $urandom;
        log_rd_en = ($urandom_range(0, 99) < 30);
        start     = ($urandom_range(0, 99) < 2);
        exp_addr  = $urandom_range(0, 7);
        exp_data  = $urandom_range(0, 3);
        max_cycles = CYC_W'($urandom_range(0, 60));
        reset     = ($urandom_range(0, 99) >= 1);
        step();
      end
      reset = 1; start = 0; memwrite = 0; log_rd_en = 0;
      $display("txn random_run %0d: pass=%0d fail=%0d timeout=%0d cycles=%0d stores=%0d",
               r, pass, fail, timeout, cycle_count, store_count);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
